// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot controller: gate state encoding and
// default sizing constants.
package parking_pkg;

   typedef enum logic {
      GATE_IDLE = 1'b0,
      GATE_OPEN = 1'b1
   } gate_state_t;

   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_GATE_HOLD = 3;
   // Wide enough for the largest legal hold time (255).
   localparam int TIMER_W       = 8;

endpackage

// File: rtl/parking_slot_alloc.sv
// Combinational priority encoder: returns the lowest-index set bit of the
// free bitmap, plus a flag telling whether any slot is free at all.
module parking_slot_alloc #(
   parameter  int NUM_SLOTS = 4,
   localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
   input  logic [NUM_SLOTS-1:0] free,
   output logic [SLOT_W-1:0]    index,
   output logic                 any_free
);

   always_comb begin
      index    = '0;
      any_free = |free;
      // Scan from the top so the lowest free index wins last.
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free[i]) begin
            index = SLOT_W'(i);
         end
      end
   end

endmodule

// File: rtl/parking_fsm_param.sv
// Parking lot controller: occupancy bitmap, free-slot counter, lowest-free
// slot allocation and a gate that stays open GATE_HOLD cycles after activity.
module parking_fsm_param
   import parking_pkg::*;
#(
   parameter  int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter  int GATE_HOLD = DEF_GATE_HOLD,
   localparam int SLOT_W    = $clog2(NUM_SLOTS),
   localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 entry_signal,
   input  logic                 exit_signal,
   input  logic [SLOT_W-1:0]    exit_slot,
   output logic                 is_open,
   output logic                 is_full,
   output logic [NUM_SLOTS-1:0] spots,
   output logic [CNT_W-1:0]     capacity,
   output logic [SLOT_W-1:0]    location,
   output logic                 entry_reject,
   output logic                 exit_error
);

   localparam logic [TIMER_W-1:0] HOLD = TIMER_W'(GATE_HOLD);

   logic [NUM_SLOTS-1:0] exit_mask_p0;
   logic [NUM_SLOTS-1:0] spots_freed_p0;
   logic [NUM_SLOTS-1:0] entry_mask_p0;
   logic [NUM_SLOTS-1:0] spots_nxt_p0;
   logic [CNT_W-1:0]     cap_nxt_p0;
   logic [SLOT_W-1:0]    alloc_idx_p0;
   logic                 any_free_p0;
   logic                 exit_ok_p0;
   logic                 entry_ok_p0;
   logic                 event_p0;

   gate_state_t          state, state_nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt;

   // Stage p0: exit is applied first so a same-cycle entry can reuse the slot.
   // An out-of-range exit_slot shifts the mask out entirely and reads as unoccupied.
   always_comb begin
      exit_mask_p0   = NUM_SLOTS'(1) << exit_slot;
      exit_ok_p0     = exit_signal && (|(spots & exit_mask_p0));
      spots_freed_p0 = exit_ok_p0 ? (spots & ~exit_mask_p0) : spots;
   end

   parking_slot_alloc #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_alloc (
      .free     (~spots_freed_p0),
      .index    (alloc_idx_p0),
      .any_free (any_free_p0)
   );

   always_comb begin
      entry_ok_p0   = entry_signal && any_free_p0;
      entry_mask_p0 = entry_ok_p0 ? (NUM_SLOTS'(1) << alloc_idx_p0) : '0;
      spots_nxt_p0  = spots_freed_p0 | entry_mask_p0;
      event_p0      = exit_ok_p0 || entry_ok_p0;
      cap_nxt_p0    = capacity;
      case ({exit_ok_p0, entry_ok_p0})
         2'b10:   cap_nxt_p0 = capacity + CNT_W'(1);
         2'b01:   cap_nxt_p0 = capacity - CNT_W'(1);
         default: cap_nxt_p0 = capacity;
      endcase
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      case (state)
         GATE_IDLE: begin
            if (event_p0) begin
               state_nxt = GATE_OPEN;
               timer_nxt = HOLD;
            end
         end
         GATE_OPEN: begin
            if (event_p0) begin
               timer_nxt = HOLD;
            end else if (timer <= TIMER_W'(1)) begin
               state_nxt = GATE_IDLE;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer - TIMER_W'(1);
            end
         end
         default: begin
            state_nxt = GATE_IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   // Stage p1: every visible output is a register loaded from stage p0.
   always_ff @(posedge clk) begin
      if (reset) begin
         spots        <= '0;
         capacity     <= CNT_W'(NUM_SLOTS);
         location     <= '0;
         is_full      <= 1'b0;
         entry_reject <= 1'b0;
         exit_error   <= 1'b0;
         state        <= GATE_IDLE;
         timer        <= '0;
      end else begin
         spots        <= spots_nxt_p0;
         capacity     <= cap_nxt_p0;
         is_full      <= (cap_nxt_p0 == '0);
         entry_reject <= entry_signal && !any_free_p0;
         exit_error   <= exit_signal && !exit_ok_p0;
         state        <= state_nxt;
         timer        <= timer_nxt;
         if (entry_ok_p0) begin
            location <= alloc_idx_p0;
         end
      end
   end

   assign is_open = (state == GATE_OPEN);

endmodule

// File: tb/tb_parking_fsm_param.sv
// Bench for parking_fsm_param (NUM_SLOTS=4, GATE_HOLD=3): vectors carry their
// expected outputs, which are queued at drive time and checked one cycle later.
module tb_parking_fsm_param;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       entry_signal = 1'b0;
   logic       exit_signal = 1'b0;
   logic [1:0] exit_slot = '0;
   logic       is_open, is_full, entry_reject, exit_error;
   logic [3:0] spots;
   logic [2:0] capacity;
   logic [1:0] location;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       rst;
      logic       ent;
      logic       ext;
      logic [1:0] slot;
      logic [3:0] spots;
      logic [2:0] cap;
      logic [1:0] loc;
      logic       full;
      logic       open;
      logic       rej;
      logic       err;
   } vec_t;

   vec_t exp_q[$];
   vec_t tbl[19];

   parking_fsm_param #(
      .NUM_SLOTS (4),
      .GATE_HOLD (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .entry_signal (entry_signal),
      .exit_signal  (exit_signal),
      .exit_slot    (exit_slot),
      .is_open      (is_open),
      .is_full      (is_full),
      .spots        (spots),
      .capacity     (capacity),
      .location     (location),
      .entry_reject (entry_reject),
      .exit_error   (exit_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input string tag, input vec_t v);
      vec_t e;
      @(negedge clk);
      reset        = v.rst;
      entry_signal = v.ent;
      exit_signal  = v.ext;
      exit_slot    = v.slot;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".spots"},    8'(spots),        8'(e.spots));
         check({tag, ".capacity"}, 8'(capacity),     8'(e.cap));
         check({tag, ".location"}, 8'(location),     8'(e.loc));
         check({tag, ".is_full"},  8'(is_full),      8'(e.full));
         check({tag, ".is_open"},  8'(is_open),      8'(e.open));
         check({tag, ".reject"},   8'(entry_reject), 8'(e.rej));
         check({tag, ".exit_err"}, 8'(exit_error),   8'(e.err));
      end
   endtask

   initial begin
      //            rst  ent  ext  slot   spots    cap   loc   full open rej  err
      // Fill the lot, reject when full, then swap a slot while full.
      tbl[0]  = '{1'b1,1'b0,1'b0,2'd0,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b1,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0};
      tbl[2]  = '{1'b0,1'b1,1'b0,2'd0,4'b0011,3'd2,2'd1,1'b0,1'b1,1'b0,1'b0};
      tbl[3]  = '{1'b0,1'b1,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b1,1'b0,1'b0};
      tbl[4]  = '{1'b0,1'b1,1'b0,2'd0,4'b1111,3'd0,2'd3,1'b1,1'b1,1'b0,1'b0};
      tbl[5]  = '{1'b0,1'b1,1'b0,2'd0,4'b1111,3'd0,2'd3,1'b1,1'b1,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b0,2'd0,4'b1111,3'd0,2'd3,1'b1,1'b1,1'b0,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b0,2'd0,4'b1111,3'd0,2'd3,1'b1,1'b0,1'b0,1'b0};
      tbl[8]  = '{1'b0,1'b1,1'b1,2'd1,4'b1111,3'd0,2'd1,1'b1,1'b1,1'b0,1'b0};
      tbl[9]  = '{1'b1,1'b0,1'b0,2'd0,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0};
      // Build 0101, then invalid exits must not touch state or reopen the gate.
      tbl[10] = '{1'b0,1'b1,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0};
      tbl[11] = '{1'b0,1'b1,1'b0,2'd0,4'b0011,3'd2,2'd1,1'b0,1'b1,1'b0,1'b0};
      tbl[12] = '{1'b0,1'b1,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b1,1'b0,1'b0};
      tbl[13] = '{1'b0,1'b0,1'b1,2'd1,4'b0101,3'd2,2'd2,1'b0,1'b1,1'b0,1'b0};
      tbl[14] = '{1'b0,1'b0,1'b1,2'd1,4'b0101,3'd2,2'd2,1'b0,1'b1,1'b0,1'b1};
      tbl[15] = '{1'b0,1'b0,1'b1,2'd3,4'b0101,3'd2,2'd2,1'b0,1'b1,1'b0,1'b1};
      tbl[16] = '{1'b0,1'b0,1'b0,2'd0,4'b0101,3'd2,2'd2,1'b0,1'b0,1'b0,1'b0};
      // Lowest free slot, and an entry reusing a slot freed in the same cycle.
      tbl[17] = '{1'b0,1'b1,1'b0,2'd0,4'b0111,3'd1,2'd1,1'b0,1'b1,1'b0,1'b0};
      tbl[18] = '{1'b0,1'b1,1'b1,2'd0,4'b0111,3'd1,2'd0,1'b0,1'b1,1'b0,1'b0};

      for (int i = 0; i < 19; i++) begin
         apply($sformatf("vec%0d", i), tbl[i]);
      end

      // Gate hold: one entry then idle gives exactly three open cycles.
      apply("hold_rst", '{1'b1,1'b0,1'b0,2'd0,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0});
      apply("hold_e1",  '{1'b0,1'b1,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0});
      apply("hold_i1",  '{1'b0,1'b0,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0});
      apply("hold_i2",  '{1'b0,1'b0,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0});
      apply("hold_i3",  '{1'b0,1'b0,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b0,1'b0,1'b0});

      // Second entry during the second open cycle restarts the hold.
      apply("ext_e1",   '{1'b0,1'b1,1'b0,2'd0,4'b0011,3'd2,2'd1,1'b0,1'b1,1'b0,1'b0});
      apply("ext_i1",   '{1'b0,1'b0,1'b0,2'd0,4'b0011,3'd2,2'd1,1'b0,1'b1,1'b0,1'b0});
      apply("ext_e2",   '{1'b0,1'b1,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b1,1'b0,1'b0});
      apply("ext_i2",   '{1'b0,1'b0,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b1,1'b0,1'b0});
      apply("ext_i3",   '{1'b0,1'b0,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b1,1'b0,1'b0});
      apply("ext_i4",   '{1'b0,1'b0,1'b0,2'd0,4'b0111,3'd1,2'd2,1'b0,1'b0,1'b0,1'b0});

      // Reset mid-OPEN with 0011 wins over a simultaneous entry and exit.
      apply("mid_rst",  '{1'b1,1'b0,1'b0,2'd0,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0});
      apply("mid_e1",   '{1'b0,1'b1,1'b0,2'd0,4'b0001,3'd3,2'd0,1'b0,1'b1,1'b0,1'b0});
      apply("mid_e2",   '{1'b0,1'b1,1'b0,2'd0,4'b0011,3'd2,2'd1,1'b0,1'b1,1'b0,1'b0});
      apply("mid_hit",  '{1'b1,1'b1,1'b1,2'd1,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0});
      apply("mid_idle", '{1'b0,1'b0,1'b0,2'd0,4'b0000,3'd4,2'd0,1'b0,1'b0,1'b0,1'b0});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
